// File: rtl/alu_sched_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_sched_pkg;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_CLO  = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_op_sched_if.sv
// Request/result bundle between two requesters, the scheduler and the downstream stage.
// Latency: n/a (wires only).
// Backpressure: o_READY0/1 toward requesters, i_READY from downstream. Optional o_OVF with ALU_OP_SCHED_OVF_EN.
interface alu_op_sched_if #(parameter int WIDTH = 4);
    logic             i_VALID0;
    logic             i_VALID1;
    logic             o_READY0;
    logic             o_READY1;
    logic [1:0]       i_OP0;
    logic [1:0]       i_OP1;
    logic [WIDTH-1:0] i_A0;
    logic [WIDTH-1:0] i_B0;
    logic [WIDTH-1:0] i_A1;
    logic [WIDTH-1:0] i_B1;
    logic             o_VALID;
    logic             i_READY;
    logic [WIDTH-1:0] o_Y;
    logic             o_ID;
    logic             o_ERR;
`ifdef ALU_OP_SCHED_OVF_EN
    logic             o_OVF;
`endif

    // Requester + downstream consumer side
    modport master (
        output i_VALID0, i_VALID1, i_OP0, i_OP1, i_A0, i_B0, i_A1, i_B1, i_READY,
        input  o_READY0, o_READY1, o_VALID, o_Y, o_ID, o_ERR
`ifdef ALU_OP_SCHED_OVF_EN
        , input o_OVF
`endif
    );

    // Scheduler side
    modport slave (
        input  i_VALID0, i_VALID1, i_OP0, i_OP1, i_A0, i_B0, i_A1, i_B1, i_READY,
        output o_READY0, o_READY1, o_VALID, o_Y, o_ID, o_ERR
`ifdef ALU_OP_SCHED_OVF_EN
        , output o_OVF
`endif
    );
endinterface

// File: rtl/alu_clo_seq.sv
// Iterative leading-ones scanner over {B,A}, one bit examined per cycle.
// Latency: min(count+1, 2*WIDTH) cycles after start; done is combinational on the final edge.
// Backpressure: none; caller must not start while busy.
module alu_clo_seq
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] load,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   count
);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(2*WIDTH-1);
    localparam logic [WIDTH-1:0] CNT_FULL = WIDTH'(2*WIDTH);

    logic [2*WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               step;

    // Keep shifting while the MSB is a one and the count has not saturated
    always_comb begin
        step  = busy_q & c_q[2*WIDTH-1] & (cnt_q != CNT_LAST);
        done  = busy_q & ~step;
        busy  = busy_q;
        // A one still in the MSB on the final edge means every bit was a one
        count = c_q[2*WIDTH-1] ? CNT_FULL : cnt_q;
    end

    // Next scanner state: load on start, shift/count while scanning, stop on done
    always_comb begin
        c_d    = c_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            c_d    = load;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (step) begin
            c_d    = {c_q[2*WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
        end else if (done) begin
            busy_d = 1'b0;
        end
    end

    // Scanner registers; reset aborts any scan in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/alu_op_sched.sv
// Round-robin scheduler for two requesters sharing a SUB/NAND/CLO ALU; registered result port. Option: ALU_OP_SCHED_OVF_EN.
// Latency: 1 cycle for SUB/NAND/illegal, 1+min(count+1,2*WIDTH) for CLO.
// Backpressure: no accept during CALC or while a held result sees i_READY=0; back-to-back when i_READY=1.
module alu_op_sched
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          i_CLK,
    input  logic          i_RSTn,
    alu_op_sched_if.slave bus
);
    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               id_q, id_d;
    logic               err_q, err_d;
    logic               grant0, grant1, can_acc, rdy0, rdy1, accept, acc_id;
    logic [1:0]         acc_op;
    logic [WIDTH-1:0]   acc_a, acc_b, sub_y, alu_y;
    logic               alu_err;
    logic               clo_busy, clo_done;
    logic [WIDTH-1:0]   clo_count;
`ifdef ALU_OP_SCHED_OVF_EN
    logic               ovf_q, ovf_d, alu_ovf;
`endif

    // Arbiter: a lone requester wins; on contention the pointer decides
    always_comb begin
        grant0 = bus.i_VALID0 & (~bus.i_VALID1 | ~ptr_q);
        grant1 = bus.i_VALID1 & (~bus.i_VALID0 |  ptr_q);
    end

    // State register
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state: a held result that drains on this edge can admit the next request directly
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (acc_op == OP_CLO) ? S_CALC : S_DONE;
            S_CALC: begin
                if (clo_done)       state_d = S_DONE;
                else if (!clo_busy) state_d = S_IDLE;
            end
            S_DONE: begin
                if (bus.i_READY) begin
                    if (accept) state_d = (acc_op == OP_CLO) ? S_CALC : S_DONE;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state: acceptance window and result valid
    always_comb begin
        can_acc      = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.i_READY);
        rdy0         = i_RSTn & grant0 & can_acc;
        rdy1         = i_RSTn & grant1 & can_acc;
        accept       = rdy0 | rdy1;
        bus.o_READY0 = rdy0;
        bus.o_READY1 = rdy1;
        bus.o_VALID  = (state_q == S_DONE);
    end

    // Operand mux and single-cycle ALU for the accepted request
    always_comb begin
        acc_id  = rdy1;
        acc_op  = acc_id ? bus.i_OP1 : bus.i_OP0;
        acc_a   = acc_id ? bus.i_A1  : bus.i_A0;
        acc_b   = acc_id ? bus.i_B1  : bus.i_B0;
        sub_y   = acc_a - acc_b;
        alu_y   = '0;
        alu_err = 1'b0;
        unique case (acc_op)
            OP_SUB:  alu_y   = sub_y;
            OP_NAND: alu_y   = ~(acc_a & acc_b);
            OP_CLO:  alu_y   = '0;
            default: alu_err = 1'b1;
        endcase
`ifdef ALU_OP_SCHED_OVF_EN
        alu_ovf = (acc_op == OP_SUB) & (acc_a[WIDTH-1] ^ acc_b[WIDTH-1])
                                     & (sub_y[WIDTH-1] ^ acc_a[WIDTH-1]);
`endif
    end

    // Result register next values: capture on accept, CLO count on scan completion
    always_comb begin
        ptr_d = ptr_q;
        y_d   = y_q;
        id_d  = id_q;
        err_d = err_q;
`ifdef ALU_OP_SCHED_OVF_EN
        ovf_d = ovf_q;
`endif
        if (accept) begin
            ptr_d = ~acc_id;
            y_d   = alu_y;
            id_d  = acc_id;
            err_d = alu_err;
`ifdef ALU_OP_SCHED_OVF_EN
            ovf_d = alu_ovf;
`endif
        end else if ((state_q == S_CALC) && clo_done) begin
            y_d = clo_count;
        end
    end

    // Result and pointer registers; reset discards any held result
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            ptr_q <= 1'b0;
            y_q   <= '0;
            id_q  <= 1'b0;
            err_q <= 1'b0;
`ifdef ALU_OP_SCHED_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            ptr_q <= ptr_d;
            y_q   <= y_d;
            id_q  <= id_d;
            err_q <= err_d;
`ifdef ALU_OP_SCHED_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign bus.o_Y   = y_q;
    assign bus.o_ID  = id_q;
    assign bus.o_ERR = err_q;
`ifdef ALU_OP_SCHED_OVF_EN
    assign bus.o_OVF = ovf_q;
`endif

    alu_clo_seq #(.WIDTH(WIDTH)) u_clo (
        .clk   (i_CLK),
        .rst_n (i_RSTn),
        .start (accept & (acc_op == OP_CLO)),
        .load  ({acc_b, acc_a}),
        .busy  (clo_busy),
        .done  (clo_done),
        .count (clo_count)
    );
endmodule

// File: tb/tb_alu_op_sched.sv
// Scoreboard bench for alu_op_sched: directed requests, monitor compares every delivered result.
// Latency: checks result latency and CLO scan length per vector.
// Backpressure: exercises i_READY=0 hold and back-to-back acceptance.
module tb_alu_op_sched;
    import alu_sched_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] y;
        logic         id;
        logic         err;
        logic         ovf;
    } exp_t;

    logic i_CLK = 1'b0;
    logic i_RSTn;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 i_CLK = ~i_CLK;

    alu_op_sched_if #(.WIDTH(W)) bus ();

    alu_op_sched #(.WIDTH(W)) dut (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic push(input logic [W-1:0] y, input logic id, input logic err, input logic ovf);
        exp_t e;
        e.y = y; e.id = id; e.err = err; e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic drive(input int port, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (port == 0) begin
            bus.i_VALID0 = 1'b1; bus.i_OP0 = op; bus.i_A0 = a; bus.i_B0 = b;
        end else begin
            bus.i_VALID1 = 1'b1; bus.i_OP1 = op; bus.i_A1 = a; bus.i_B1 = b;
        end
    endtask

    task automatic idle_all();
        bus.i_VALID0 = 1'b0;
        bus.i_VALID1 = 1'b0;
    endtask

    // Issue a lone CLO request and measure the cycles until the result appears
    task automatic run_clo(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_y, input int exp_n, input string name);
        int n;
        drive(port, OP_CLO, a, b);
        push(exp_y, port[0], 1'b0, 1'b0);
        #1;
        check({name, "_ready"}, (port == 0) ? bus.o_READY0 : bus.o_READY1, 1);
        tick();
        idle_all();
        n = 0;
        while (!bus.o_VALID && n < 40) begin
            tick();
            n++;
        end
        check({name, "_calc_cycles"}, n, exp_n);
        tick();
    endtask

    // Monitor: every result transfer (valid & ready) is compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge i_CLK);
            if (i_RSTn === 1'b1 && bus.o_VALID === 1'b1 && bus.i_READY === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("mon_y",   bus.o_Y,   e.y);
                    check("mon_id",  bus.o_ID,  e.id);
                    check("mon_err", bus.o_ERR, e.err);
`ifdef ALU_OP_SCHED_OVF_EN
                    check("mon_ovf", bus.o_OVF, e.ovf);
`endif
                end
            end
        end
    end

    initial begin
        i_RSTn = 1'b0;
        bus.i_VALID0 = 1'b1; bus.i_OP0 = OP_SUB; bus.i_A0 = '0; bus.i_B0 = '0;
        bus.i_VALID1 = 1'b0; bus.i_OP1 = OP_SUB; bus.i_A1 = '0; bus.i_B1 = '0;
        bus.i_READY  = 1'b1;
        repeat (2) @(posedge i_CLK);
        #2;
        // Reset state, with a request pending
        check("rst_valid", bus.o_VALID, 0);
        check("rst_y",     bus.o_Y,     0);
        check("rst_id",    bus.o_ID,    0);
        check("rst_err",   bus.o_ERR,   0);
        check("rst_ready0", bus.o_READY0, 0);
`ifdef ALU_OP_SCHED_OVF_EN
        check("rst_ovf",   bus.o_OVF,   0);
`endif
        idle_all();
        @(negedge i_CLK);
        i_RSTn = 1'b1;
        tick();

        // Both requesters valid every cycle: grants alternate 0,1,0,1
        drive(0, OP_NAND, 4'hF, 4'h3);
        drive(1, OP_SUB,  4'h8, 4'h1);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(4'hC, 1'b0, 1'b0, 1'b0);
            else            push(4'h7, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_ready0", bus.o_READY0, (i % 2 == 0) ? 1 : 0);
            check("alt_ready1", bus.o_READY1, (i % 2 == 1) ? 1 : 0);
            tick();
        end
        idle_all();
        tick();

        // Lone SUB 3-5 = -2, one-cycle latency
        drive(0, OP_SUB, 4'd3, 4'd5);
        push(4'hE, 1'b0, 1'b0, 1'b0);
        #1;
        check("sub_ready0", bus.o_READY0, 1);
        tick();
        idle_all();
        check("sub_latency", bus.o_VALID, 1);
        tick();

        // CLO scans: three ones, all ones, leading zero
        run_clo(1, 4'b0000, 4'b1110, 4'd3, 4, "clo3");
        run_clo(0, 4'hF,    4'hF,    4'd8, 8, "clo8");
        run_clo(1, 4'b1010, 4'b0111, 4'd0, 1, "clo0");

        // Backpressure: result held for 5 cycles while req0 waits
        bus.i_READY = 1'b0;
        drive(0, OP_SUB, 4'd7, 4'd2);
        push(4'd5, 1'b0, 1'b0, 1'b0);
        #1;
        check("bp_first_ready0", bus.o_READY0, 1);
        tick();
        drive(0, OP_NAND, 4'd5, 4'd6);
        push(4'hB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_valid",  bus.o_VALID,  1);
            check("bp_hold_y",      bus.o_Y,      5);
            check("bp_hold_ready0", bus.o_READY0, 0);
            tick();
        end
        bus.i_READY = 1'b1;
        #1;
        check("bp_release_ready0", bus.o_READY0, 1);
        tick();
        idle_all();
        check("bp_next_valid", bus.o_VALID, 1);
        check("bp_next_y",     bus.o_Y,     4'hB);
        tick();

        // Illegal opcode
        drive(1, OP_ILL, 4'd5, 4'd3);
        push(4'd0, 1'b1, 1'b1, 1'b0);
        #1;
        check("ill_ready1", bus.o_READY1, 1);
        tick();
        idle_all();
        check("ill_err", bus.o_ERR, 1);
        tick();

        // Reset mid-CLO: result discarded, pointer back to requester 0
        drive(0, OP_CLO, 4'hF, 4'hF);
        #1;
        tick();
        idle_all();
        tick();
        tick();
        i_RSTn = 1'b0;
        drive(0, OP_SUB, 4'd6, 4'd1);
        drive(1, OP_SUB, 4'd2, 4'd1);
        #1;
        check("mid_rst_valid",  bus.o_VALID,  0);
        check("mid_rst_ready0", bus.o_READY0, 0);
        check("mid_rst_ready1", bus.o_READY1, 0);
        #2;
        i_RSTn = 1'b1;
        #1;
        check("post_rst_ready0", bus.o_READY0, 1);
        check("post_rst_ready1", bus.o_READY1, 0);
        push(4'd5, 1'b0, 1'b0, 1'b0);
        tick();
        idle_all();
        check("post_rst_valid", bus.o_VALID, 1);
        check("post_rst_id",    bus.o_ID,    0);
        repeat (3) tick();

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_op_sched.md
# alu_op_sched

Request scheduler and sequencer for the shared 4-bit signed ALU (subtract, NAND, leading-ones count). Two requester ports compete for the single ALU. A round-robin arbiter selects the winner. Single-cycle ops complete in one cycle; the leading-ones count runs as an iterative multi-cycle scan. Results leave through one registered READY-VALID output port, which feeds the pipeline register chain downstream.

## Interface
- WIDTH, 4, operand/result width; WIDTH >= 4 so that a count up to 2*WIDTH fits in WIDTH bits
- i_CLK  in  1  clock, rising edge
- i_RSTn  in  1  reset, asynchronous, active-low
- i_VALID0 / i_VALID1  in  1  request valid, requester 0 / 1
- o_READY0 / o_READY1  out  1  request accepted this edge when both valid and ready are high
- i_OP0 / i_OP1  in  2  opcode: 00 SUB (A-B), 01 NAND, 10 CLO (leading ones of {B,A}), 11 illegal
- i_A0, i_B0 / i_A1, i_B1  in  WIDTH  signed operands
- o_VALID  out  1  result valid
- i_READY  in  1  downstream ready
- o_Y  out  WIDTH  result
- o_ID  out  1  index of the requester that owns the result
- o_ERR  out  1  illegal opcode; o_Y = 0
- o_OVF  out  1  signed overflow of SUB; present only with the overflow macro (see Configuration)

## Operation
- FSM states:
  - IDLE: output register empty.
  - CALC: CLO scan in progress.
  - DONE: result held, o_VALID=1.
- Grant logic:
  - If exactly one i_VALIDx is high, that requester is granted.
  - If both are high, the requester named by the round-robin pointer is granted.
  - After every acceptance, the pointer moves to the other requester.
- o_READYx = grantx & (state==IDLE | (state==DONE & i_READY)). The ungranted requester always sees 0.
- On acceptance of SUB, NAND or illegal: compute combinationally, register the result, go to DONE.
- On acceptance of CLO: load c={B,A}, cnt=0, go to CALC.
- Each CALC edge:
  - If c[2W-1]=1 and cnt<2W-1: cnt++, shift c left.
  - Else if c[2W-1]=1: o_Y=2W, go to DONE.
  - Else: o_Y=cnt, go to DONE.
- DONE with i_READY=1: if a new request is accepted on the same edge, handle it as from IDLE; otherwise go to IDLE.
- DONE with i_READY=0: hold o_Y, o_ID, o_ERR, o_OVF and o_VALID stable.
- SUB wraps modulo 2^WIDTH. NAND is bitwise ~(A&B).
- Reset mid-operation aborts the scan and discards the held result. Pointer returns to requester 0.

## Timing
- Reset values:
  - o_VALID=0, o_Y=0, o_ID=0, o_ERR=0, o_OVF=0.
  - o_READY0/1 forced 0 while i_RSTn is low.
  - State IDLE, pointer=0.
- SUB, NAND and illegal ops: accepted on edge k, o_VALID=1 after edge k. Latency 1.
- CLO: min(count+1, 2W) CALC edges, then o_VALID. Latency 1 + min(count+1, 2W).
- Throughput with no backpressure and single-cycle ops: one result per cycle, because DONE with i_READY=1 accepts back-to-back.
- No request is accepted during CALC, or during DONE while i_READY=0.

## Configuration
- ALU_OP_SCHED_OVF_EN defined:
  - o_OVF port exists.
  - o_OVF=1 when a SUB has A and B of different sign and a result sign different from A.
  - o_OVF is 0 for all other ops.
- ALU_OP_SCHED_OVF_EN undefined: o_OVF port and its logic are absent. All other behaviour is identical.

## Structure
- Package alu_sched_pkg holds:
  - opcode constants OP_SUB, OP_NAND, OP_CLO, OP_ILL;
  - state encoding S_IDLE, S_CALC, S_DONE.
- Sub-module alu_clo_seq holds the iterative leading-ones scanner.
  - Ports: start, {B,A} load, busy/done, count.
  - The top level contains the arbiter, the FSM and the output register.

## Test plan
- Req0 SUB A=3, B=5 alone, i_READY=1: o_VALID one cycle later, o_Y=4'b1110 (-2), o_ID=0, o_ERR=0, o_OVF=0.
- Both valid every cycle, req0 NAND A=4'hF B=4'h3, req1 SUB A=-8 B=1, i_READY=1:
  - grants alternate 0,1,0,1;
  - req0 result o_Y=4'hC;
  - req1 result o_Y=4'h7 with o_OVF=1 (OVF build).
- Req1 CLO A=4'b0000, B=4'b1110: 4 CALC cycles, then o_Y=3, o_ID=1.
- CLO A=B=4'hF: 8 CALC cycles, o_Y=8. CLO B=4'b0xxx: 1 CALC cycle, o_Y=0.
- i_READY=0 for 5 cycles after a result, with req0 valid: o_Y held, o_READY0=0. First edge with i_READY=1 delivers the result and accepts the next request.
- Illegal op 11 gives o_ERR=1, o_Y=0. i_RSTn pulsed low mid-CLO: o_VALID=0 immediately, next grant goes to req0.
